// File: rtl/pipe_stage_regs_if.sv
// Bundle between the hazard/decode logic and the PC, IF/ID and ID/EX registers.
interface pipe_stage_regs_if #(
   parameter int unsigned STALL_CNT_W = 16
);
   // hazard controls
   logic                   stall_f;
   logic                   stall_d;
   logic                   flush_e;
   logic                   perf_clear;

   // fetch / branch redirect
   logic                   pc_src_d;
   logic [31:0]            pc_branch_d;
   logic [31:0]            instr_f;

   // decode-stage payload
   logic                   reg_write_d;
   logic                   wb_source_d;
   logic                   mem_write_d;
   logic                   alu_src_d;
   logic                   reg_dst_d;
   logic [2:0]             alu_ctrl_d;
   logic [31:0]            rd1_d;
   logic [31:0]            rd2_d;
   logic [31:0]            sign_imm_d;
   logic [4:0]             register_s_d;
   logic [4:0]             register_t_d;
   logic [4:0]             register_d_d;

   // fetch address and IF/ID contents
   logic [31:0]            pc_f;
   logic [31:0]            instr_d;
   logic [31:0]            pc_plus4_d;
   logic                   valid_d;

   // ID/EX contents
   logic                   valid_e;
   logic                   reg_write_e;
   logic                   wb_source_e;
   logic                   mem_write_e;
   logic                   alu_src_e;
   logic                   reg_dst_e;
   logic [2:0]             alu_ctrl_e;
   logic [31:0]            rd1_e;
   logic [31:0]            rd2_e;
   logic [31:0]            sign_imm_e;
   logic [4:0]             register_s_e;
   logic [4:0]             register_t_e;
   logic [4:0]             register_d_e;

   // performance counter
   logic [STALL_CNT_W-1:0] stall_cycles;

   // core side: drives controls and decode payload, observes the registers
   modport master (
      output stall_f, stall_d, flush_e, perf_clear, pc_src_d, pc_branch_d, instr_f,
             reg_write_d, wb_source_d, mem_write_d, alu_src_d, reg_dst_d, alu_ctrl_d,
             rd1_d, rd2_d, sign_imm_d, register_s_d, register_t_d, register_d_d,
      input  pc_f, instr_d, pc_plus4_d, valid_d, valid_e,
             reg_write_e, wb_source_e, mem_write_e, alu_src_e, reg_dst_e, alu_ctrl_e,
             rd1_e, rd2_e, sign_imm_e, register_s_e, register_t_e, register_d_e,
             stall_cycles
   );

   // register block side
   modport slave (
      input  stall_f, stall_d, flush_e, perf_clear, pc_src_d, pc_branch_d, instr_f,
             reg_write_d, wb_source_d, mem_write_d, alu_src_d, reg_dst_d, alu_ctrl_d,
             rd1_d, rd2_d, sign_imm_d, register_s_d, register_t_d, register_d_d,
      output pc_f, instr_d, pc_plus4_d, valid_d, valid_e,
             reg_write_e, wb_source_e, mem_write_e, alu_src_e, reg_dst_e, alu_ctrl_e,
             rd1_e, rd2_e, sign_imm_e, register_s_e, register_t_e, register_d_e,
             stall_cycles
   );
endinterface

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage MIPS core, plus a saturating
// stall-cycle counter. Every output comes straight from a flop.
module pipe_stage_regs #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   pipe_stage_regs_if.slave bus
);
   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned ALUC_W = 3;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } ifid_t;

   typedef struct packed {
      logic              reg_write;
      logic              wb_source;
      logic              mem_write;
      logic              alu_src;
      logic              reg_dst;
      logic [ALUC_W-1:0] alu_ctrl;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   sign_imm;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic              valid;
   } idex_t;

   logic [XLEN-1:0]        pc_f_q, pc_f_d;
   logic [XLEN-1:0]        pc_plus4_f;
   ifid_t                  ifid_q, ifid_d;
   idex_t                  idex_q, idex_d;
   logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   assign pc_plus4_f = pc_f_q + XLEN'(4);

   // Next PC: stall holds, a decode-resolved branch redirects, else sequential.
   always_comb begin
      pc_f_d = pc_f_q;
      if (!bus.stall_f) begin
         if (bus.pc_src_d) pc_f_d = bus.pc_branch_d;
         else              pc_f_d = pc_plus4_f;
      end
   end

   // IF/ID: stall holds; a taken branch squashes the wrong-path fetch.
   always_comb begin
      ifid_d = ifid_q;
      if (!bus.stall_d) begin
         if (bus.pc_src_d) begin
            ifid_d = '0;
         end else begin
            ifid_d.instr    = bus.instr_f;
            ifid_d.pc_plus4 = pc_plus4_f;
            ifid_d.valid    = 1'b1;
         end
      end
   end

   // ID/EX: never stalls; flush inserts a bubble.
   always_comb begin
      idex_d = '0;
      if (!bus.flush_e) begin
         idex_d.reg_write = bus.reg_write_d;
         idex_d.wb_source = bus.wb_source_d;
         idex_d.mem_write = bus.mem_write_d;
         idex_d.alu_src   = bus.alu_src_d;
         idex_d.reg_dst   = bus.reg_dst_d;
         idex_d.alu_ctrl  = bus.alu_ctrl_d;
         idex_d.rd1       = bus.rd1_d;
         idex_d.rd2       = bus.rd2_d;
         idex_d.sign_imm  = bus.sign_imm_d;
         idex_d.rs        = bus.register_s_d;
         idex_d.rt        = bus.register_t_d;
         idex_d.rd        = bus.register_d_d;
         idex_d.valid     = ifid_q.valid;
      end
   end

   // Stall counter: clear beats increment, saturates at all-ones.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (bus.perf_clear) begin
         stall_cycles_d = '0;
      end else if (bus.stall_d && !(&stall_cycles_q)) begin
         stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f_q         <= RESET_PC;
         ifid_q         <= '0;
         idex_q         <= '0;
         stall_cycles_q <= '0;
      end else begin
         pc_f_q         <= pc_f_d;
         ifid_q         <= ifid_d;
         idex_q         <= idex_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign bus.pc_f         = pc_f_q;
   assign bus.instr_d      = ifid_q.instr;
   assign bus.pc_plus4_d   = ifid_q.pc_plus4;
   assign bus.valid_d      = ifid_q.valid;
   assign bus.valid_e      = idex_q.valid;
   assign bus.reg_write_e  = idex_q.reg_write;
   assign bus.wb_source_e  = idex_q.wb_source;
   assign bus.mem_write_e  = idex_q.mem_write;
   assign bus.alu_src_e    = idex_q.alu_src;
   assign bus.reg_dst_e    = idex_q.reg_dst;
   assign bus.alu_ctrl_e   = idex_q.alu_ctrl;
   assign bus.rd1_e        = idex_q.rd1;
   assign bus.rd2_e        = idex_q.rd2;
   assign bus.sign_imm_e   = idex_q.sign_imm;
   assign bus.register_s_e = idex_q.rs;
   assign bus.register_t_e = idex_q.rt;
   assign bus.register_d_e = idex_q.rd;
   assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_stage_regs.sv
// Scoreboarded bench for pipe_stage_regs: directed test-plan scenarios
// followed by randomized hazard traffic.
module tb_pipe_stage_regs;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int unsigned CW       = 16;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   pipe_stage_regs_if #(.STALL_CNT_W(CW)) bus ();

   pipe_stage_regs #(.RESET_PC(RESET_PC), .STALL_CNT_W(CW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Architectural view of every output after a clock edge.
   typedef struct {
      logic [31:0]   pc_f, instr_d, pc_plus4_d, rd1_e, rd2_e, sign_imm_e;
      logic          valid_d, valid_e, reg_write_e, wb_source_e, mem_write_e, alu_src_e, reg_dst_e;
      logic [2:0]    alu_ctrl_e;
      logic [4:0]    rs_e, rt_e, rd_e;
      logic [CW-1:0] stall_cycles;
   } exp_t;

   exp_t m;
   exp_t exp_q[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endfunction

   // Reference: compute the outputs after the next edge from current outputs and inputs.
   function automatic exp_t predict(exp_t cur);
      exp_t n;
      n = cur;
      if (reset) begin
         n = '{default: '0};
         n.pc_f = RESET_PC;
         return n;
      end
      if (!bus.stall_f) n.pc_f = bus.pc_src_d ? bus.pc_branch_d : cur.pc_f + 32'd4;
      if (!bus.stall_d) begin
         if (bus.pc_src_d) begin
            n.instr_d = 32'h0; n.pc_plus4_d = 32'h0; n.valid_d = 1'b0;
         end else begin
            n.instr_d = bus.instr_f; n.pc_plus4_d = cur.pc_f + 32'd4; n.valid_d = 1'b1;
         end
      end
      if (bus.flush_e) begin
         n.valid_e = 0; n.reg_write_e = 0; n.wb_source_e = 0; n.mem_write_e = 0;
         n.alu_src_e = 0; n.reg_dst_e = 0; n.alu_ctrl_e = 0; n.rd1_e = 0; n.rd2_e = 0;
         n.sign_imm_e = 0; n.rs_e = 0; n.rt_e = 0; n.rd_e = 0;
      end else begin
         n.valid_e = cur.valid_d; n.reg_write_e = bus.reg_write_d; n.wb_source_e = bus.wb_source_d;
         n.mem_write_e = bus.mem_write_d; n.alu_src_e = bus.alu_src_d; n.reg_dst_e = bus.reg_dst_d;
         n.alu_ctrl_e = bus.alu_ctrl_d; n.rd1_e = bus.rd1_d; n.rd2_e = bus.rd2_d;
         n.sign_imm_e = bus.sign_imm_d; n.rs_e = bus.register_s_d; n.rt_e = bus.register_t_d;
         n.rd_e = bus.register_d_d;
      end
      if (bus.perf_clear)                       n.stall_cycles = '0;
      else if (bus.stall_d && cur.stall_cycles != {CW{1'b1}}) n.stall_cycles = cur.stall_cycles + 1'b1;
      return n;
   endfunction

   // Issue one cycle: predict, enqueue expectation, advance past the edge.
   task automatic apply();
      m = predict(m);
      exp_q.push_back(m);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_payload();
      bus.instr_f      = $urandom;
      bus.reg_write_d  = 1'($urandom_range(0, 1));
      bus.wb_source_d  = 1'($urandom_range(0, 1));
      bus.mem_write_d  = 1'($urandom_range(0, 1));
      bus.alu_src_d    = 1'($urandom_range(0, 1));
      bus.reg_dst_d    = 1'($urandom_range(0, 1));
      bus.alu_ctrl_d   = 3'($urandom_range(0, 7));
      bus.rd1_d        = $urandom;
      bus.rd2_d        = $urandom;
      bus.sign_imm_d   = $urandom;
      bus.register_s_d = 5'($urandom_range(0, 31));
      bus.register_t_d = 5'($urandom_range(0, 31));
      bus.register_d_d = 5'($urandom_range(0, 31));
      bus.pc_branch_d  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
   endtask

   task automatic quiet();
      bus.stall_f = 0; bus.stall_d = 0; bus.flush_e = 0; bus.pc_src_d = 0; bus.perf_clear = 0;
   endtask

   // Monitor: compare every output one delta after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc_f",         bus.pc_f,                 e.pc_f);
            chk("instr_d",      bus.instr_d,              e.instr_d);
            chk("pc_plus4_d",   bus.pc_plus4_d,           e.pc_plus4_d);
            chk("valid_d",      32'(bus.valid_d),         32'(e.valid_d));
            chk("valid_e",      32'(bus.valid_e),         32'(e.valid_e));
            chk("reg_write_e",  32'(bus.reg_write_e),     32'(e.reg_write_e));
            chk("wb_source_e",  32'(bus.wb_source_e),     32'(e.wb_source_e));
            chk("mem_write_e",  32'(bus.mem_write_e),     32'(e.mem_write_e));
            chk("alu_src_e",    32'(bus.alu_src_e),       32'(e.alu_src_e));
            chk("reg_dst_e",    32'(bus.reg_dst_e),       32'(e.reg_dst_e));
            chk("alu_ctrl_e",   32'(bus.alu_ctrl_e),      32'(e.alu_ctrl_e));
            chk("rd1_e",        bus.rd1_e,                e.rd1_e);
            chk("rd2_e",        bus.rd2_e,                e.rd2_e);
            chk("sign_imm_e",   bus.sign_imm_e,           e.sign_imm_e);
            chk("register_s_e", 32'(bus.register_s_e),    32'(e.rs_e));
            chk("register_t_e", 32'(bus.register_t_e),    32'(e.rt_e));
            chk("register_d_e", 32'(bus.register_d_e),    32'(e.rd_e));
            chk("stall_cycles", 32'(bus.stall_cycles),    32'(e.stall_cycles));
         end
      end
   end

   // Stimulus with test-plan spot checks against fixed values.
   initial begin
      n_checks = 0;
      n_errors = 0;
      m = '{default: '0};
      quiet();
      rand_payload();
      reset = 1'b1;
      apply();
      apply();
      chk("rst_pc_f",  bus.pc_f, 32'h0040_0000);
      chk("rst_instr", bus.instr_d, 32'h0);
      chk("rst_vd",    32'(bus.valid_d), 32'h0);
      chk("rst_ve",    32'(bus.valid_e), 32'h0);
      chk("rst_rw_e",  32'(bus.reg_write_e), 32'h0);
      chk("rst_stall", 32'(bus.stall_cycles), 32'h0);

      // free run
      reset = 1'b0;
      rand_payload();
      bus.instr_f = 32'h2008_0005;
      bus.reg_write_d = 1'b1; bus.register_t_d = 5'd8;
      apply();
      chk("run_instr_d", bus.instr_d, 32'h2008_0005);
      chk("run_pc4_d",   bus.pc_plus4_d, 32'h0040_0004);
      chk("run_pc_f",    bus.pc_f, 32'h0040_0004);
      chk("run_vd",      32'(bus.valid_d), 32'h1);
      rand_payload();
      bus.reg_write_d = 1'b1; bus.register_t_d = 5'd8;
      apply();
      chk("run_ve",      32'(bus.valid_e), 32'h1);
      chk("run_rt_e",    32'(bus.register_t_e), 32'd8);

      // load-use bubble
      bus.stall_f = 1; bus.stall_d = 1; bus.flush_e = 1;
      rand_payload();
      bus.reg_write_d = 1'b1; bus.register_t_d = 5'd8;
      apply();
      chk("lu_pc_f",   bus.pc_f, 32'h0040_0008);
      chk("lu_ve",     32'(bus.valid_e), 32'h0);
      chk("lu_rw_e",   32'(bus.reg_write_e), 32'h0);
      chk("lu_rt_e",   32'(bus.register_t_e), 32'h0);
      chk("lu_stall",  32'(bus.stall_cycles), 32'h1);
      quiet();
      rand_payload();
      apply();
      chk("lu_rel_pc", bus.pc_f, 32'h0040_000C);

      // branch redirect
      rand_payload();
      bus.pc_src_d = 1; bus.pc_branch_d = 32'h0040_0020;
      apply();
      chk("br_pc_f",  bus.pc_f, 32'h0040_0020);
      chk("br_instr", bus.instr_d, 32'h0);
      chk("br_vd",    32'(bus.valid_d), 32'h0);
      quiet();
      rand_payload();
      bus.instr_f = 32'h1234_5678;
      apply();

      // branch during stall is deferred
      bus.stall_f = 1; bus.stall_d = 1; bus.pc_src_d = 1; bus.pc_branch_d = 32'h0040_0040;
      apply();
      chk("brst_pc_f",  bus.pc_f, 32'h0040_0024);
      chk("brst_instr", bus.instr_d, 32'h1234_5678);
      chk("brst_vd",    32'(bus.valid_d), 32'h1);
      bus.stall_f = 0; bus.stall_d = 0;
      apply();
      chk("brrel_pc_f", bus.pc_f, 32'h0040_0040);
      chk("brrel_vd",   32'(bus.valid_d), 32'h0);

      // PC wrap
      quiet();
      bus.pc_src_d = 1; bus.pc_branch_d = 32'hFFFF_FFF8;
      apply();
      bus.pc_src_d = 0;
      apply();
      chk("wrap_pre", bus.pc_f, 32'hFFFF_FFFC);
      apply();
      chk("wrap_pc_f", bus.pc_f, 32'h0);
      chk("wrap_pc4",  bus.pc_plus4_d, 32'h0);

      // counter saturation
      bus.perf_clear = 1;
      apply();
      bus.perf_clear = 0;
      bus.stall_f = 1; bus.stall_d = 1;
      for (int i = 0; i < 65540; i++) begin
         bus.flush_e = 1'($urandom_range(0, 1));
         apply();
      end
      chk("sat_stall", 32'(bus.stall_cycles), 32'h0000_FFFF);
      bus.perf_clear = 1;
      apply();
      chk("clr_stall", 32'(bus.stall_cycles), 32'h0);
      quiet();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rand_payload();
         if ($urandom_range(0, 4) == 0) begin
            bus.stall_f = 1; bus.stall_d = 1; bus.flush_e = 1;
         end else begin
            bus.stall_f = ($urandom_range(0, 9) == 0);
            bus.stall_d = ($urandom_range(0, 9) == 0);
            bus.flush_e = ($urandom_range(0, 9) == 0);
         end
         bus.pc_src_d   = ($urandom_range(0, 6) == 0);
         bus.perf_clear = ($urandom_range(0, 30) == 0);
         reset          = ($urandom_range(0, 99) == 0);
         apply();
      end
      reset = 0;
      quiet();

      // reset in the middle of a stall with a live E stage
      rand_payload();
      apply();
      rand_payload();
      apply();
      chk("pre_rst_ve", 32'(bus.valid_e), 32'h1);
      bus.stall_f = 1; bus.stall_d = 1; bus.flush_e = 1;
      reset = 1;
      apply();
      chk("mrst_pc_f",  bus.pc_f, 32'h0040_0000);
      chk("mrst_ve",    32'(bus.valid_e), 32'h0);
      chk("mrst_vd",    32'(bus.valid_d), 32'h0);
      chk("mrst_instr", bus.instr_d, 32'h0);
      chk("mrst_stall", 32'(bus.stall_cycles), 32'h0);
      reset = 0;
      quiet();

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Sequential consumer of the hazard unit's controls: holds the PC and the IF/ID and ID/EX pipeline registers of the 5-stage MIPS core.
- Applies stall_f, stall_d and flush_e, and redirects fetch on taken branches resolved in decode.
- Feeds execute-stage register numbers and control back to the hazard unit.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_f  input  1  hold PC.
- stall_d  input  1  hold IF/ID register.
- flush_e  input  1  load bubble into ID/EX.
- pc_src_d  input  1  branch taken in decode.
- pc_branch_d  input  32  branch target.
- instr_f  input  32  instruction-memory read data for pc_f.
- reg_write_d, wb_source_d, mem_write_d, alu_src_d, reg_dst_d  input  1 each  decode control.
- alu_ctrl_d  input  3  decode ALU control.
- rd1_d, rd2_d  input  32  register-file read data.
- sign_imm_d  input  32  sign-extended immediate.
- register_s_d, register_t_d, register_d_d  input  5 each  rs, rt, rd fields.
- perf_clear  input  1  clear stall counter.
- pc_f  output  32  fetch address.
- instr_d, pc_plus4_d  output  32  IF/ID contents.
- valid_d, valid_e  output  1  stage holds a real instruction.
- reg_write_e, wb_source_e, mem_write_e, alu_src_e, reg_dst_e  output  1 each  ID/EX control.
- alu_ctrl_e  output  3  ID/EX ALU control.
- rd1_e, rd2_e, sign_imm_e  output  32  ID/EX data.
- register_s_e, register_t_e, register_d_e  output  5 each  ID/EX register numbers; also returned to the hazard unit.
- stall_cycles  output  STALL_CNT_W  saturating stall count.

Behaviour:
- Reset (synchronous, highest priority):
  - pc_f=RESET_PC; stall_cycles=0.
  - All IF/ID and ID/EX outputs 0, including valid_d and valid_e.
- PC register, priority stall_f > redirect > increment:
  - stall_f=1: hold.
  - Else pc_src_d=1: pc_f<=pc_branch_d.
  - Else pc_f<=pc_f+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- IF/ID register, priority stall_d > flush-on-branch > load:
  - stall_d=1: hold all fields.
  - Else pc_src_d=1: instr_d=0 (NOP), pc_plus4_d=0, valid_d=0.
  - Else instr_d<=instr_f, pc_plus4_d<=pc_f+4, valid_d<=1.
- ID/EX register, no stall:
  - flush_e=1: all control, data and register fields 0, valid_e=0.
  - Else load every *_d input into the matching *_e output; valid_e<=valid_d.
- Simultaneous stall_d=1 and pc_src_d=1: stall wins, branch ignored that cycle; decode re-presents the branch after the stall releases.
- The hazard unit drives stall_f=stall_d=flush_e together: PC and IF/ID hold while a bubble enters E. Each input is still honoured independently.
- Latency:
  - instr_f to instr_d: 1 cycle.
  - *_d to *_e: 1 cycle.
  - pc_src_d redirect visible on pc_f: next edge.
- stall_cycles:
  - Priority reset > perf_clear > increment.
  - Increments by 1 on each edge where stall_d=1; saturates at all-ones, no wrap.
  - perf_clear and stall_d in the same cycle: result 0.
- No combinational paths from inputs to outputs; every output is a register.

Test Plan:
- Reset with RESET_PC=32'h0040_0000 -> pc_f=0x00400000, instr_d=0, valid_d=0, valid_e=0, reg_write_e=0, stall_cycles=0.
- Free run, instr_f=0x20080005 at 0x00400000 -> next edge: instr_d=0x20080005, pc_plus4_d=0x00400004, pc_f=0x00400004, valid_d=1. Following edge: E fields loaded, valid_e=1.
- Load-use: stall_f=stall_d=flush_e=1 for one cycle -> pc_f and instr_d unchanged, valid_e=0, reg_write_e=0, register_t_e=0, stall_cycles=1. Release -> normal flow resumes.
- Branch: pc_src_d=1, pc_branch_d=0x00400020 -> pc_f=0x00400020, instr_d=0, valid_d=0. Same cycle with stall_d=stall_f=1 -> pc_f and instr_d hold, redirect deferred.
- Wrap and saturation:
  - pc_f=0xFFFFFFFC, no stall -> pc_f=0.
  - 65540 consecutive stall cycles -> stall_cycles=0xFFFF.
  - perf_clear=1 -> stall_cycles=0.
- Reset asserted mid-stall with valid_e=1 -> next edge: all outputs at reset values, pc_f=RESET_PC.
